// File: rtl/jpeg_bit_unpacker_if.sv
// Byte-in / bit-window-out handshake between the scan byte source, the
// bit unpacker and the Huffman/VLI decoder that peeks and consumes bits.
interface jpeg_bit_unpacker_if #(
  parameter int CODE_W = 32,
  parameter int BUF_W  = 64,
  parameter int CNT_W  = $clog2(BUF_W + 1),
  parameter int LEN_W  = $clog2(CODE_W + 1)
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic [CODE_W-1:0] peek_bits;
  logic [CNT_W-1:0]  peek_avail;
  logic              consume_en;
  logic [LEN_W-1:0]  consume_len;
  logic              byte_align;
  logic              marker_valid;
  logic [7:0]        marker_code;
  logic              marker_ack;
  logic              consume_err;

  modport master (
    output in_valid, in_byte, consume_en, consume_len, byte_align, marker_ack,
    input  in_ready, peek_bits, peek_avail, marker_valid, marker_code, consume_err
  );

  modport slave (
    input  in_valid, in_byte, consume_en, consume_len, byte_align, marker_ack,
    output in_ready, peek_bits, peek_avail, marker_valid, marker_code, consume_err
  );
endinterface

// File: rtl/jpeg_bit_unpacker.sv
// JPEG scan bit unpacker: strips FF00 stuffing and FF fill bytes, stops on
// markers, and presents an MSB-aligned bit window that is consumed variably.
module jpeg_bit_unpacker #(
  parameter int CODE_W = 32,
  parameter int BUF_W  = 64,
  parameter int CNT_W  = $clog2(BUF_W + 1),
  parameter int LEN_W  = $clog2(CODE_W + 1)
) (
  input logic                clk,
  input logic                rst_n,
  jpeg_bit_unpacker_if.slave bus
);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       phase_q, phase_d;
  logic             ff_pending_q, ff_pending_d;
  logic             marker_valid_q, marker_valid_d;
  logic [7:0]       marker_code_q, marker_code_d;
  logic             consume_err_q, consume_err_d;

  logic             accept;
  logic             app_en;
  logic [7:0]       app_byte;
  logic [2:0]       align_n;
  logic [CNT_W-1:0] len_ext;

  // Ready looks only at registered state so the source never sees a
  // combinational path from the decoder's consume request.
  assign bus.in_ready     = !marker_valid_q && (cnt_q <= CNT_W'(BUF_W - 8));
  assign bus.peek_bits    = buf_q[BUF_W-1 -: CODE_W];
  assign bus.peek_avail   = cnt_q;
  assign bus.marker_valid = marker_valid_q;
  assign bus.marker_code  = marker_code_q;
  assign bus.consume_err  = consume_err_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign len_ext = CNT_W'(bus.consume_len);

  always_comb begin
    buf_d          = buf_q;
    cnt_d          = cnt_q;
    phase_d        = phase_q;
    ff_pending_d   = ff_pending_q;
    marker_valid_d = marker_valid_q;
    marker_code_d  = marker_code_q;
    consume_err_d  = consume_err_q;
    app_en         = 1'b0;
    app_byte       = 8'h00;
    align_n        = 3'd0;

    if (bus.consume_en) begin
      if (len_ext <= cnt_q) begin
        buf_d   = buf_d << len_ext;
        cnt_d   = cnt_d - len_ext;
        phase_d = phase_d + bus.consume_len[2:0];
      end else begin
        consume_err_d = 1'b1;
      end
    end

    // Bits left before the boundary always equal (8 - phase) mod 8, and the
    // buffer holds at least that many because only whole bytes are appended.
    if (bus.byte_align) begin
      align_n = 3'd0 - phase_d;
      buf_d   = buf_d << align_n;
      cnt_d   = cnt_d - CNT_W'(align_n);
      phase_d = 3'd0;
    end

    if (bus.marker_ack && marker_valid_q) begin
      marker_valid_d = 1'b0;
    end

    if (accept) begin
      if (!ff_pending_q) begin
        if (bus.in_byte == 8'hFF) begin
          ff_pending_d = 1'b1;
        end else begin
          app_en   = 1'b1;
          app_byte = bus.in_byte;
        end
      end else if (bus.in_byte == 8'h00) begin
        app_en       = 1'b1;
        app_byte     = 8'hFF;
        ff_pending_d = 1'b0;
      end else if (bus.in_byte != 8'hFF) begin
        marker_valid_d = 1'b1;
        marker_code_d  = bus.in_byte;
        ff_pending_d   = 1'b0;
      end
    end

    // Unused buffer bits are kept zero, so OR-ing the byte in is enough.
    if (app_en) begin
      buf_d = buf_d | ({app_byte, {(BUF_W-8){1'b0}}} >> cnt_d);
      cnt_d = cnt_d + CNT_W'(8);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q          <= '0;
      cnt_q          <= '0;
      phase_q        <= '0;
      ff_pending_q   <= 1'b0;
      marker_valid_q <= 1'b0;
      marker_code_q  <= 8'h00;
      consume_err_q  <= 1'b0;
    end else begin
      buf_q          <= buf_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      ff_pending_q   <= ff_pending_d;
      marker_valid_q <= marker_valid_d;
      marker_code_q  <= marker_code_d;
      consume_err_q  <= consume_err_d;
    end
  end

endmodule

// File: tb/tb_jpeg_bit_unpacker.sv
// Bench for jpeg_bit_unpacker: a bit-queue reference model feeds a scoreboard
// of expected outputs that is drained one entry per clock.
module tb_jpeg_bit_unpacker;

  localparam int CODE_W = 32;
  localparam int BUF_W  = 64;

  typedef struct {
    logic [31:0] bits;
    int          avail;
    logic        mv;
    logic [7:0]  mc;
    logic        err;
    logic        rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  jpeg_bit_unpacker_if #(.CODE_W(CODE_W), .BUF_W(BUF_W)) bus ();

  jpeg_bit_unpacker #(.CODE_W(CODE_W), .BUF_W(BUF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_fail = 0;
  string cur    = "init";
  exp_t  sb[$];

  bit          mq[$];
  bit          m_ff;
  int          m_phase;
  bit          m_mv;
  logic [7:0]  m_mc;
  bit          m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", cur, tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return !m_mv && (mq.size() <= BUF_W - 8);
  endfunction

  task automatic m_push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_byte     = 8'h00;
    bus.consume_en  = 1'b0;
    bus.consume_len = '0;
    bus.byte_align  = 1'b0;
    bus.marker_ack  = 1'b0;
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit ce, input int len,
                      input bit al, input bit ack);
    exp_t e;
    bit   acc;
    int   n;
    bus.in_valid    = v;
    bus.in_byte     = b;
    bus.consume_en  = ce;
    bus.consume_len = 6'(len);
    bus.byte_align  = al;
    bus.marker_ack  = ack;
    acc = v && m_ready();
    if (ce) begin
      if (len <= mq.size()) begin
        for (int i = 0; i < len; i++) void'(mq.pop_front());
        m_phase = (m_phase + len) % 8;
      end else begin
        m_err = 1'b1;
      end
    end
    if (al) begin
      n = (8 - m_phase) % 8;
      for (int i = 0; i < n; i++) if (mq.size() > 0) void'(mq.pop_front());
      m_phase = 0;
    end
    if (ack && m_mv) m_mv = 1'b0;
    if (acc) begin
      if (!m_ff) begin
        if (b == 8'hFF) m_ff = 1'b1;
        else m_push_byte(b);
      end else if (b == 8'h00) begin
        m_push_byte(8'hFF);
        m_ff = 1'b0;
      end else if (b != 8'hFF) begin
        m_mv = 1'b1;
        m_mc = b;
        m_ff = 1'b0;
      end
    end
    for (int i = 0; i < 32; i++) e.bits[31-i] = (i < mq.size()) ? mq[i] : 1'b0;
    e.avail = mq.size();
    e.mv    = m_mv;
    e.mc    = m_mc;
    e.err   = m_err;
    e.rdy   = m_ready();
    sb.push_back(e);
    @(posedge clk);
    #1;
    idle();
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("bits",  bus.peek_bits, e.bits);
      chk("avail", bus.peek_avail, e.avail);
      chk("mv",    bus.marker_valid, e.mv);
      chk("mc",    bus.marker_code, e.mc);
      chk("err",   bus.consume_err, e.err);
      chk("rdy",   bus.in_ready, e.rdy);
    end
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic consume(input int len);
    step(1'b0, 8'h00, 1'b1, len, 1'b0, 1'b0);
  endtask

  // Reset is asserted between clock edges to exercise its asynchronous path.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ff = 0; m_phase = 0; m_mv = 0; m_mc = 8'h00; m_err = 0;
    chk("rst_bits",  bus.peek_bits, 0);
    chk("rst_avail", bus.peek_avail, 0);
    chk("rst_mv",    bus.marker_valid, 0);
    chk("rst_mc",    bus.marker_code, 0);
    chk("rst_err",   bus.consume_err, 0);
    chk("rst_rdy",   bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] b;
    int lim;
    idle();

    cur = "basic";
    do_reset();
    send(8'hA5); send(8'h3C);
    chk("t1_avail", bus.peek_avail, 16);
    chk("t1_bits",  bus.peek_bits, 32'hA53C0000);
    consume(3);
    chk("t1_avail_c", bus.peek_avail, 13);
    chk("t1_bits_c",  bus.peek_bits, 32'h29E00000);

    cur = "stuff";
    do_reset();
    send(8'hFF); send(8'h00); send(8'h12);
    chk("t2_avail", bus.peek_avail, 16);
    chk("t2_bits",  bus.peek_bits, 32'hFF120000);
    chk("t2_mv",    bus.marker_valid, 0);

    cur = "marker";
    do_reset();
    send(8'h55); send(8'hFF); send(8'hD3);
    chk("t3_avail", bus.peek_avail, 8);
    chk("t3_mv",    bus.marker_valid, 1);
    chk("t3_mc",    bus.marker_code, 8'hD3);
    chk("t3_rdy",   bus.in_ready, 0);
    send(8'h77); send(8'h77);
    chk("t3_held", bus.peek_avail, 8);
    step(1'b1, 8'h77, 1'b0, 0, 1'b0, 1'b1);
    chk("t3_rdy_ack", bus.in_ready, 1);
    chk("t3_mc_hold", bus.marker_code, 8'hD3);
    send(8'h77);
    chk("t3_resume", bus.peek_bits, 32'h55770000);

    cur = "fill";
    do_reset();
    send(8'hFF); send(8'hFF); send(8'hFF);
    chk("t4_nomark", bus.marker_valid, 0);
    send(8'hD9);
    chk("t4_mv",    bus.marker_valid, 1);
    chk("t4_mc",    bus.marker_code, 8'hD9);
    chk("t4_avail", bus.peek_avail, 0);
    step(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1);
    chk("t4_clear", bus.marker_valid, 0);
    consume(0);
    chk("t4_empty", bus.peek_bits, 0);

    cur = "full";
    do_reset();
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("t5_avail", bus.peek_avail, 64);
    chk("t5_rdy",   bus.in_ready, 0);
    send(8'h09);
    chk("t5_block", bus.peek_avail, 64);
    consume(8);
    chk("t5_rdy_c", bus.in_ready, 1);
    chk("t5_bits",  bus.peek_bits, 32'h02030405);

    cur = "align";
    do_reset();
    send(8'h80); send(8'hC0);
    consume(3);
    step(1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0);
    chk("t6_avail", bus.peek_avail, 8);
    chk("t6_bits",  bus.peek_bits, 32'hC0000000);
    consume(9);
    chk("t6_err",   bus.consume_err, 1);
    chk("t6_keep",  bus.peek_avail, 8);
    step(1'b1, 8'h11, 1'b1, 4, 1'b1, 1'b0);
    chk("t6_order", bus.peek_bits, 32'h11000000);
    chk("t6_sticky", bus.consume_err, 1);

    cur = "random";
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)       b = 8'hFF;
      else if (r == 3) b = 8'h00;
      else if (r == 4) b = 8'hD0 + 8'($urandom_range(0, 9));
      else             b = 8'($urandom);
      lim = (mq.size() + 2 > 32) ? 32 : mq.size() + 2;
      step($urandom_range(0, 3) != 0, b,
           $urandom_range(0, 2) == 0, $urandom_range(0, lim),
           $urandom_range(0, 7) == 0,
           m_mv && ($urandom_range(0, 3) == 0));
    end

    cur = "midreset";
    for (int i = 0; i < 4; i++) send(8'h5A);
    do_reset();
    send(8'h3C);
    chk("t7_bits", bus.peek_bits, 32'h3C000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jpeg_bit_unpacker.md
Name: jpeg_bit_unpacker

Overview:
- Entropy-decode front end: takes the JPEG scan byte stream and turns it into a continuous MSB-first bit window for the Huffman/VLI decoder.
- Removes 0xFF00 byte stuffing, discards 0xFF fill bytes, and stops on markers (RSTn, EOI, ...), reporting the marker code.
- The decoder peeks up to CODE_W bits and consumes a variable number each cycle. This is the read-side counterpart of the Huffman bit packer.

Parameters:
CODE_W, 32, peek window width in bits (matches the Huffman_t code width)
BUF_W, 64, internal bit buffer depth; multiple of 8, at least CODE_W+8
CNT_W, $clog2(BUF_W+1), width of bit-count fields

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_byte valid
in_byte  in  8  scan byte, stream order
in_ready  out  1  byte accepted when in_valid && in_ready
peek_bits  out  CODE_W  next unconsumed bits, MSB-aligned; bits beyond peek_avail read 0
peek_avail  out  CNT_W  valid bits in buffer (0..BUF_W)
consume_en  in  1  drop consume_len bits this cycle
consume_len  in  $clog2(CODE_W+1)  bits to drop, 0..CODE_W
byte_align  in  1  discard bits up to the next byte boundary of the destuffed stream
marker_valid  out  1  marker detected; input stalled
marker_code  out  8  second byte of the marker
marker_ack  in  1  clears marker_valid and resumes input
consume_err  out  1  sticky: consume_len exceeded peek_avail

Behaviour:
- Reset (async, rst_n low): buffer=0, cnt=0, ff_pending=0, bit_phase=0. Outputs: peek_avail=0, peek_bits=0, marker_valid=0, marker_code=0, consume_err=0.
- in_ready = !marker_valid && (cnt <= BUF_W-8). It is combinational from registers only and does not depend on the same-cycle consume. After reset in_ready=1.
- Byte handling when accepted:
  - ff_pending=0, byte!=FF: append byte.
  - ff_pending=0, byte==FF: set ff_pending; append nothing.
  - ff_pending=1, byte==00: append 0xFF; clear ff_pending.
  - ff_pending=1, byte==FF: fill byte; discard; stay pending.
  - ff_pending=1, other byte: marker. marker_code=byte, marker_valid=1, ff_pending=0; append nothing.
- Appended bytes land immediately after the last valid bit, MSB first. They are visible on peek_bits/peek_avail the cycle after acceptance (1-cycle latency).
- consume_en with consume_len<=cnt:
  - Next cycle, buffer is shifted left by consume_len and cnt decreases by consume_len.
  - bit_phase=(bit_phase+consume_len) mod 8.
- consume_en with consume_len>cnt: consume is ignored and consume_err is set. consume_err stays set until reset.
- byte_align: drops (8-bit_phase) mod 8 further bits; bit_phase becomes 0. It is applied after the same-cycle consume.
- Same-cycle order: consume, then align, then append. New cnt = cnt - consumed - aligned + (8 if a byte is appended). This never exceeds BUF_W because in_ready is gated on the pre-cycle cnt.
- marker_valid holds, and input stays stalled, until marker_ack. Bits already in the buffer can still be peeked and consumed while stalled.
- marker_ack clears marker_valid next cycle; marker_code holds its last value. marker_ack with marker_valid=0 has no effect.
- Empty buffer: peek_bits=0, peek_avail=0; consume of 0 bits is legal and is a no-op.
- Reset mid-operation discards all buffered bits, pending FF and marker state.

Test Plan:
- Bytes A5,3C -> peek_avail=16, peek_bits=0xA53C0000. Then consume 3 -> peek_avail=13, peek_bits=0x29E00000.
- Bytes FF,00,12 -> peek_avail=16, peek_bits=0xFF120000; no marker_valid.
- Bytes 55,FF,D3 -> peek_avail=8, marker_valid=1, marker_code=D3, in_ready=0. Next byte is held off until marker_ack; then in_ready=1.
- Bytes FF,FF,FF,D9 -> exactly one marker, code D9; peek_avail=0.
- Eight bytes 01..08 with no consume -> peek_avail=64, in_ready=0. Consume 8 -> in_ready=1 the next cycle.
- Bytes 80,C0: consume 3, then byte_align -> peek_avail=8, peek_bits=0xC0000000. Then consume 9 with avail=8 -> ignored, consume_err=1, avail stays 8.
